alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Reservation station and issue scheduler for the single-cycle ALU in the out-of-order core.
- Buffers dispatched ALU ops until both operands are available.
- Captures operands from the result broadcast bus (CDB) and issues the oldest ready op to the ALU, at most one per cycle.
- Sits between rename/dispatch and the ALU; the ALU's registered result returns on the CDB.

Parameters:
- DEPTH, 4, number of queue entries (>= 2).
- TAG_W, 6, physical-register tag width; equals width of RESULT.dest / INSTRUCTION_ALU.rd.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries and of the issue register.
- dispatch_valid  in  1  dispatch presents an op.
- dispatch_ready  out  1  queue can accept an op this cycle.
- dispatch_entry  in  ALU_RS_ENTRY  {alu_func, rd, lhs_tag, lhs_rdy, lhs, rhs_tag, rhs_rdy, rhs}.
- cdb_valid  in  1  result broadcast valid.
- cdb  in  RESULT  {dest, data} broadcast.
- issue_valid  out  1  issue register holds a live op.
- issue  out  INSTRUCTION_ALU  op to ALU {alu_func, rd, lhs, rhs}.

Behaviour:
- Storage: collapsing queue. Entry 0 is the oldest. Each entry holds a valid bit plus ALU_RS_ENTRY. A count register tracks occupancy.
- dispatch_ready = (count < DEPTH), taken from registered occupancy only. No credit for a same-cycle issue, so a full queue stays not-ready even while issuing.
- Accept: dispatch_valid && dispatch_ready && !flush. The new entry is written at index count, or count-1 when an entry issues in the same cycle.
- Wakeup: when cdb_valid is high, every valid entry with a not-ready operand whose tag == cdb.dest captures cdb.data and sets that rdy bit.
  - The same match is applied to the incoming dispatch_entry, so a dispatch coinciding with its producer's broadcast is captured.
  - lhs and rhs may both match the same broadcast.
- Select: combinational, picks the lowest-index valid entry with both rdy bits set.
- Issue register:
  - On the clock edge, the selected entry is removed. Older entries stay put; younger entries shift down by one.
  - The entry is loaded into the issue register and issue_valid = 1 in the next cycle.
  - With nothing selected: issue_valid = 0 and issue.alu_func = ALU_NOP, so the ALU produces result_valid = 0. rd, lhs and rhs are zero.
- Latency:
  - Dispatch with both operands ready at edge N: issuable from cycle N+1, issue_valid at N+2.
  - CDB wakeup at edge N: issuable from N+1 (without the optional feature).
- One issue per cycle. The ALU never back-pressures, so there is no issue handshake.
- flush: at the next edge, all valid bits and count are cleared, issue_valid = 0 and issue.alu_func = ALU_NOP. Flush overrides dispatch and select in that cycle.
- Reset, also mid-operation: asynchronously clears valid bits, count = 0, issue_valid = 0, issue = {ALU_NOP, 0, 0, 0}. dispatch_ready is 1 after reset.
- Invariant: count == popcount(valid). Valid entries always occupy 0..count-1 contiguously.

Optional Feature:
- Macro ALU_IQ_CDB_BYPASS_EN.
- Defined: select also treats an operand as ready when it matches the current-cycle CDB. The operand value is muxed from cdb.data into the issue register, so a consumer woken at edge N issues at edge N (back-to-back dependent ops).
- Undefined: select uses stored rdy bits only, giving one bubble between dependent ops.

Decomposition:
- riscv_isa package:
  - add ALU_RS_ENTRY struct;
  - add ALU_NOP encoding of the alu_func enum, distinct from ADD..SRA.
- Existing INSTRUCTION_ALU and RESULT are reused unchanged.
- One sub-module: alu_iq_select. Purely combinational lowest-index ready pick, with one-hot grant and index outputs, parameterised by DEPTH.

Test Plan:
- Reset mid-stream:
  - Stimulus: 3 entries queued, then reset pulsed asynchronously between edges.
  - Required: issue_valid = 0 immediately, dispatch_ready = 1, count = 0, issue.alu_func = ALU_NOP.
- Ready dispatch:
  - Stimulus: ADD rd=5, lhs=3, rhs=4, both rdy, dispatched at edge 0.
  - Required: issue_valid = 1 after edge 1 with {ADD, 5, 3, 4}; ALU result {5, 7} one cycle later.
- Wakeup:
  - Stimulus: SUB rd=9, lhs_tag=12 not ready, rhs=1. Then cdb {12, 10} at edge 3.
  - Required: issue after edge 4 (edge 3 with ALU_IQ_CDB_BYPASS_EN) with lhs = 10; the ALU computes 9.
- Age order:
  - Stimulus: entries A (waiting) and B, C (ready) dispatched in order; A woken later.
  - Required: B issues before C; A issues after its wakeup; entries compact with no gaps.
- Full queue:
  - Stimulus: fill DEPTH=4 entries, all not ready.
  - Required: dispatch_ready = 0 even while one entry issues. It returns to 1 the cycle after count drops to 3.
- Collisions:
  - Stimulus 1: dispatch with lhs_tag=7 coincides with cdb {7, 0xFFFF_FFFF}.
    - Required: captured as ready.
  - Stimulus 2: flush asserted together with dispatch_valid.
    - Required: next cycle count = 0 and issue_valid = 0.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// Shared ISA types for the out-of-order core: ALU op encodings, CDB result,
// ALU instruction and ALU reservation-station entry.
package riscv_isa;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_NOP
  } alu_func_t;

  typedef struct packed {
    logic [TAG_W-1:0] dest;
    logic [XLEN-1:0]  data;
  } RESULT;

  typedef struct packed {
    alu_func_t        alu_func;
    logic [TAG_W-1:0] rd;
    logic [XLEN-1:0]  lhs;
    logic [XLEN-1:0]  rhs;
  } INSTRUCTION_ALU;

  typedef struct packed {
    alu_func_t        alu_func;
    logic [TAG_W-1:0] rd;
    logic [TAG_W-1:0] lhs_tag;
    logic             lhs_rdy;
    logic [XLEN-1:0]  lhs;
    logic [TAG_W-1:0] rhs_tag;
    logic             rhs_rdy;
    logic [XLEN-1:0]  rhs;
  } ALU_RS_ENTRY;

  // Operand capture from the result broadcast; both operands may match at once.
  function automatic ALU_RS_ENTRY rs_capture(ALU_RS_ENTRY e, logic v, RESULT r);
    ALU_RS_ENTRY o;
    o = e;
    if (v && !e.lhs_rdy && (e.lhs_tag == r.dest)) begin
      o.lhs     = r.data;
      o.lhs_rdy = 1'b1;
    end
    if (v && !e.rhs_rdy && (e.rhs_tag == r.dest)) begin
      o.rhs     = r.data;
      o.rhs_rdy = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Lowest-index ready pick for the ALU issue queue (one-hot grant plus index).
module alu_iq_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest requesting index is the last to win.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU reservation station: CDB wakeup, oldest-ready issue, one op per cycle.
// Optional macro ALU_IQ_CDB_BYPASS_EN lets select see same-cycle CDB operands.
module alu_issue_queue
  import riscv_isa::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           dispatch_valid,
  output logic           dispatch_ready,
  input  ALU_RS_ENTRY    dispatch_entry,
  input  logic           cdb_valid,
  input  RESULT          cdb,
  output logic           issue_valid,
  output INSTRUCTION_ALU issue
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_reg, valid_next;
  ALU_RS_ENTRY      entry_reg  [DEPTH];
  ALU_RS_ENTRY      entry_next [DEPTH];
  ALU_RS_ENTRY      woken      [DEPTH];
  ALU_RS_ENTRY      shifted    [DEPTH];
  logic [DEPTH-1:0] shifted_valid;
  logic [CNT_W-1:0] count_reg, count_next, wr_idx;
  logic [DEPTH-1:0] req, grant, shift;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             accept;
  ALU_RS_ENTRY      dispatch_woken;
  logic             issue_valid_reg, issue_valid_next;
  INSTRUCTION_ALU   issue_reg, issue_next;

  assign dispatch_ready = (count_reg < CNT_W'(DEPTH));
  assign accept         = dispatch_valid && dispatch_ready && !flush;
  assign wr_idx         = count_reg - CNT_W'(sel_any);
  assign dispatch_woken = rs_capture(dispatch_entry, cdb_valid, cdb);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign woken[gi] = rs_capture(entry_reg[gi], cdb_valid, cdb);
`ifdef ALU_IQ_CDB_BYPASS_EN
    assign req[gi] = valid_reg[gi] && woken[gi].lhs_rdy && woken[gi].rhs_rdy;
`else
    assign req[gi] = valid_reg[gi] && entry_reg[gi].lhs_rdy && entry_reg[gi].rhs_rdy;
`endif
    // Younger neighbour that slides into this slot when an older entry issues.
    if (gi < DEPTH - 1) begin : g_shift
      assign shifted[gi]       = woken[gi+1];
      assign shifted_valid[gi] = valid_reg[gi+1];
    end else begin : g_top
      assign shifted[gi]       = woken[gi];
      assign shifted_valid[gi] = 1'b0;
    end
  end

  alu_iq_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Every slot at or above the granted one collapses down by one.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc      = acc | grant[i];
      shift[i] = acc;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_next[i] = shift[i] ? shifted_valid[i] : valid_reg[i];
      entry_next[i] = shift[i] ? shifted[i] : woken[i];
      if (accept && (wr_idx == CNT_W'(i))) begin
        valid_next[i] = 1'b1;
        entry_next[i] = dispatch_woken;
      end
    end
    if (flush) valid_next = '0;
    count_next = flush ? '0 : (count_reg + CNT_W'(accept) - CNT_W'(sel_any));
  end

  always_comb begin
    issue_valid_next = 1'b0;
    issue_next       = '{alu_func: ALU_NOP, rd: '0, lhs: '0, rhs: '0};
    if (!flush && sel_any) begin
      issue_valid_next    = 1'b1;
      issue_next.alu_func = woken[sel_idx].alu_func;
      issue_next.rd       = woken[sel_idx].rd;
      issue_next.lhs      = woken[sel_idx].lhs;
      issue_next.rhs      = woken[sel_idx].rhs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg       <= '0;
      count_reg       <= '0;
      issue_valid_reg <= 1'b0;
      issue_reg       <= '{alu_func: ALU_NOP, rd: '0, lhs: '0, rhs: '0};
    end else begin
      valid_reg       <= valid_next;
      count_reg       <= count_next;
      issue_valid_reg <= issue_valid_next;
      issue_reg       <= issue_next;
    end
  end

  // Payload is qualified by valid_reg, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
  end

  assign issue_valid = issue_valid_reg;
  assign issue       = issue_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (default build, no CDB bypass).
module tb_alu_issue_queue;
  import riscv_isa::*;

  logic           clk;
  logic           reset;
  logic           flush;
  logic           dispatch_valid;
  logic           dispatch_ready;
  ALU_RS_ENTRY    dispatch_entry;
  logic           cdb_valid;
  RESULT          cdb;
  logic           issue_valid;
  INSTRUCTION_ALU issue;

  int checks = 0;
  int errors = 0;

  alu_issue_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_entry (dispatch_entry),
    .cdb_valid      (cdb_valid),
    .cdb            (cdb),
    .issue_valid    (issue_valid),
    .issue          (issue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ALU_RS_ENTRY mk(alu_func_t f, logic [5:0] rd,
                                     logic [5:0] lt, logic lr, logic [31:0] l,
                                     logic [5:0] rt, logic rr, logic [31:0] r);
    ALU_RS_ENTRY e;
    e.alu_func = f;  e.rd = rd;
    e.lhs_tag = lt;  e.lhs_rdy = lr;  e.lhs = l;
    e.rhs_tag = rt;  e.rhs_rdy = rr;  e.rhs = r;
    return e;
  endfunction

  function automatic logic [31:0] alu_model(INSTRUCTION_ALU op);
    case (op.alu_func)
      ALU_ADD: return op.lhs + op.rhs;
      ALU_SUB: return op.lhs - op.rhs;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (issue_valid)
      $display("t=%0t issue rd=%0d lhs=%0h rhs=%0h", $time, issue.rd, issue.lhs, issue.rhs);
  endtask

  task automatic disp(input ALU_RS_ENTRY e);
    dispatch_valid = 1'b1;
    dispatch_entry = e;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0;
    cdb_valid = 1'b0; cdb = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_ready", dispatch_ready, 1'b1);
    check("rst_func", issue.alu_func, ALU_NOP);
    check("rst_count", dut.count_reg, 0);

    // Ready dispatch: ADD 3+4 -> rd 5
    disp(mk(ALU_ADD, 5, 0, 1'b1, 3, 0, 1'b1, 4));
    cyc();
    idle();
    check("rdy_not_yet", issue_valid, 1'b0);
    cyc();
    check("rdy_valid", issue_valid, 1'b1);
    check("rdy_func", issue.alu_func, ALU_ADD);
    check("rdy_rd", issue.rd, 5);
    check("rdy_lhs", issue.lhs, 3);
    check("rdy_rhs", issue.rhs, 4);
    check("rdy_alu", alu_model(issue), 7);
    cyc();
    check("rdy_drained", issue_valid, 1'b0);

    // Wakeup: SUB waits on tag 12, CDB delivers 10
    disp(mk(ALU_SUB, 9, 12, 1'b0, 0, 0, 1'b1, 1));
    cyc();
    idle();
    cyc();
    check("wk_waiting", issue_valid, 1'b0);
    cdb_valid = 1'b1; cdb = '{dest: 12, data: 10};
    cyc();
    idle();
    check("wk_bubble", issue_valid, 1'b0);
    cyc();
    check("wk_valid", issue_valid, 1'b1);
    check("wk_rd", issue.rd, 9);
    check("wk_lhs", issue.lhs, 10);
    check("wk_alu", alu_model(issue), 9);
    cyc();

    // Age order: A waits on tag 20, B and C ready
    disp(mk(ALU_ADD, 1, 20, 1'b0, 0, 0, 1'b1, 2));
    cyc();
    disp(mk(ALU_ADD, 2, 0, 1'b1, 1, 0, 1'b1, 1));
    cyc();
    disp(mk(ALU_ADD, 3, 0, 1'b1, 5, 0, 1'b1, 5));
    cyc();
    idle();
    check("age_b_first", issue.rd, 2);
    check("age_b_valid", issue_valid, 1'b1);
    check("age_count", dut.count_reg, 2);
    check("age_compact", dut.valid_reg, 4'b0011);
    check("age_slot1", dut.entry_reg[1].rd, 3);
    cdb_valid = 1'b1; cdb = '{dest: 20, data: 100};
    cyc();
    idle();
    check("age_c_second", issue.rd, 3);
    check("age_c_alu", alu_model(issue), 10);
    cyc();
    check("age_a_last", issue.rd, 1);
    check("age_a_alu", alu_model(issue), 102);
    check("age_empty", dut.count_reg, 0);
    cyc();

    // Full queue: four waiting entries
    for (int i = 0; i < 4; i++) begin
      disp(mk(ALU_ADD, 6'(10 + i), 6'(30 + i), 1'b0, 0, 0, 1'b1, 2));
      cyc();
    end
    check("full_ready", dispatch_ready, 1'b0);
    check("full_count", dut.count_reg, 4);
    disp(mk(ALU_ADD, 15, 0, 1'b1, 7, 0, 1'b1, 8));
    cdb_valid = 1'b1; cdb = '{dest: 30, data: 1};
    cyc();
    cdb_valid = 1'b0;
    check("full_ready_while_issue", dispatch_ready, 1'b0);
    cyc();
    check("full_issue_rd", issue.rd, 10);
    check("full_issue_alu", alu_model(issue), 3);
    check("full_count3", dut.count_reg, 3);
    check("full_ready_back", dispatch_ready, 1'b1);
    cyc();
    idle();
    check("full_e_accepted", dut.count_reg, 4);
    check("full_e_not_yet", issue_valid, 1'b0);
    cyc();
    check("full_e_issue", issue.rd, 15);
    check("full_e_alu", alu_model(issue), 15);
    flush = 1'b1;
    cyc();
    idle();
    check("full_flushed", dut.count_reg, 0);

    // Collision 1: dispatch coincides with producer broadcast
    disp(mk(ALU_ADD, 7, 7, 1'b0, 0, 0, 1'b1, 1));
    cdb_valid = 1'b1; cdb = '{dest: 7, data: 32'hFFFF_FFFF};
    cyc();
    idle();
    cyc();
    check("col_captured", issue_valid, 1'b1);
    check("col_lhs", issue.lhs, 32'hFFFF_FFFF);
    check("col_alu", alu_model(issue), 0);
    cyc();

    // Collision 2: flush with dispatch while a ready op waits
    disp(mk(ALU_ADD, 4, 0, 1'b1, 1, 0, 1'b1, 1));
    cyc();
    disp(mk(ALU_ADD, 8, 0, 1'b1, 2, 0, 1'b1, 2));
    flush = 1'b1;
    cyc();
    idle();
    check("fl_count", dut.count_reg, 0);
    check("fl_issue_valid", issue_valid, 1'b0);
    check("fl_func", issue.alu_func, ALU_NOP);
    cyc();
    check("fl_nothing_left", issue_valid, 1'b0);

    // Reset mid-stream
    disp(mk(ALU_ADD, 20, 40, 1'b0, 0, 0, 1'b1, 0));
    cyc();
    disp(mk(ALU_ADD, 21, 0, 1'b1, 3, 0, 1'b1, 3));
    cyc();
    disp(mk(ALU_ADD, 22, 41, 1'b0, 0, 0, 1'b1, 0));
    cyc();
    idle();
    check("mr_pre_valid", issue_valid, 1'b1);
    check("mr_pre_count", dut.count_reg, 2);
    #2 reset = 1'b1;
    #1;
    check("mr_issue_valid", issue_valid, 1'b0);
    check("mr_ready", dispatch_ready, 1'b1);
    check("mr_count", dut.count_reg, 0);
    check("mr_func", issue.alu_func, ALU_NOP);
    #2 reset = 1'b0;
    cyc();
    check("mr_post_valid", issue_valid, 1'b0);
    check("mr_post_count", dut.count_reg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
